// File: rtl/uart_ctrl_status.sv
// uart_ctrl_status
//
// Register file that sits between the peripheral bus and the UART TX/RX
// engines. It holds four registers: CTRL, STATUS, IRQ_EN and DIV.
// A write to CTRL or DIV only lands in a shadow copy first. The shadow is
// copied into the active configuration in the first cycle where both
// engines are idle. This way a frame never sees its baud rate or parity
// change part-way through.
//
// Register map (i_Paddr):
//   0 CTRL   [2:0] baud sel, [4:3] parity, [5] custom divisor, [6] TX en, [7] RX en
//            (reads back the shadow copy)
//   1 STATUS [0] tx busy, [1] rx full, [2] overrun, [3] parity err,
//            [4] frame err, [5] tx done, [6] cfg pending
//            Writing 1 to bits [5:2] clears those sticky flags.
//   2 IRQ_EN [4:0] rx_full, overrun, parity, frame, tx_done
//   3 DIV    custom divisor (a written 0 is stored as 1; reads the shadow)
//
// Optional feature macro: STATUS_IRQ_EN
//   defined   - IRQ_EN register, tx_done tracking and o_Irq are present.
//   undefined - IRQ_EN reads 0 and ignores writes, STATUS[5] reads 0,
//               and o_Irq is tied low.
//
// Ports:
//   i_Pclk, i_Reset          clock, synchronous active-high reset
//   i_Enable, i_Pwrite       one-cycle bus strobe, 1 = write
//   i_Paddr, i_Data          register select, write data
//   o_Rdata, o_Ready         registered read data, access acknowledge pulse
//   i_Tx_Busy, i_Rx_Busy     engine activity (gate the config apply)
//   i_Rx_Full                RX holding register occupied (level)
//   i_Rx_Overrun, i_Parity_Err, i_Frame_Err   one-cycle error events
//   o_Baud, o_Parity         active divisor and parity mode
//   o_Tx_En, o_Rx_En         active engine enables
//   o_Cfg_Applied            pulse when the shadow config becomes active
//   o_Irq                    registered interrupt level
module uart_ctrl_status #(
    parameter int CLK_HZ = 10000000,
    parameter int DIV_W  = 16,
    parameter int DATA_W = 16
) (
    input  logic              i_Pclk,
    input  logic              i_Reset,
    input  logic              i_Enable,
    input  logic              i_Pwrite,
    input  logic [1:0]        i_Paddr,
    input  logic [DATA_W-1:0] i_Data,
    output logic [DATA_W-1:0] o_Rdata,
    output logic              o_Ready,
    input  logic              i_Tx_Busy,
    input  logic              i_Rx_Busy,
    input  logic              i_Rx_Full,
    input  logic              i_Rx_Overrun,
    input  logic              i_Parity_Err,
    input  logic              i_Frame_Err,
    output logic [DIV_W-1:0]  o_Baud,
    output logic [1:0]        o_Parity,
    output logic              o_Tx_En,
    output logic              o_Rx_En,
    output logic              o_Cfg_Applied,
    output logic              o_Irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    localparam logic [7:0]       CTRL_RESET = 8'h03;
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

    // Clocks-per-bit for each standard rate, truncated to the port width.
    function automatic logic [DIV_W-1:0] rate_div(input int sel);
        int rate;
        case (sel)
            0:       rate = 1200;
            1:       rate = 2400;
            2:       rate = 4800;
            3:       rate = 9600;
            4:       rate = 19200;
            5:       rate = 38400;
            6:       rate = 57600;
            default: rate = 115200;
        endcase
        return DIV_W'(CLK_HZ / rate);
    endfunction

    logic [DIV_W-1:0] baud_tab [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_baud_tab
            assign baud_tab[gi] = rate_div(gi);
        end
    endgenerate

    // Register state
    logic [7:0]        shadow_ctrl_reg;
    logic [7:0]        active_ctrl_reg;
    logic [DIV_W-1:0]  shadow_div_reg;
    logic [DIV_W-1:0]  active_div_reg;
    logic              pending_reg;
    logic              overrun_reg;
    logic              parity_reg;
    logic              frame_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              ready_reg;
    logic              cfg_applied_reg;

    // Bus decode
    logic wr_stb, rd_stb;
    logic wr_ctrl, wr_div, wr_status, wr_irq_en;
    logic apply_now;
    logic [3:0] w1c;               // clear requests for STATUS[5:2]
    logic [DIV_W-1:0] div_wr_val;
    logic [4:0] irq_en_val;
    logic       tx_done_val;
    logic [6:0] status_word;
    logic [DATA_W-1:0] rdata_next;

    assign wr_stb    = i_Enable & i_Pwrite;
    assign rd_stb    = i_Enable & ~i_Pwrite;
    assign wr_ctrl   = wr_stb && (i_Paddr == ADDR_CTRL);
    assign wr_status = wr_stb && (i_Paddr == ADDR_STATUS);
    assign wr_irq_en = wr_stb && (i_Paddr == ADDR_IRQ_EN);
    assign wr_div    = wr_stb && (i_Paddr == ADDR_DIV);

    // Apply uses the shadow as it stood before this edge. A write landing
    // in the same cycle therefore keeps pending set for the new value.
    assign apply_now = pending_reg & ~i_Tx_Busy & ~i_Rx_Busy;

    assign w1c        = wr_status ? i_Data[5:2] : 4'b0000;
    assign div_wr_val = (i_Data[DIV_W-1:0] == '0) ? DIV_ONE : i_Data[DIV_W-1:0];

    assign status_word = {pending_reg, tx_done_val, frame_reg, parity_reg,
                          overrun_reg, i_Rx_Full, i_Tx_Busy};

    always_comb begin
        rdata_next = '0;
        case (i_Paddr)
            ADDR_CTRL:   rdata_next[7:0]       = shadow_ctrl_reg;
            ADDR_STATUS: rdata_next[6:0]       = status_word;
            ADDR_IRQ_EN: rdata_next[4:0]       = irq_en_val;
            default:     rdata_next[DIV_W-1:0] = shadow_div_reg;
        endcase
    end

    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            shadow_ctrl_reg <= CTRL_RESET;
            active_ctrl_reg <= CTRL_RESET;
            shadow_div_reg  <= DIV_ONE;
            active_div_reg  <= DIV_ONE;
            pending_reg     <= 1'b0;
            overrun_reg     <= 1'b0;
            parity_reg      <= 1'b0;
            frame_reg       <= 1'b0;
            rdata_reg       <= '0;
            ready_reg       <= 1'b0;
            cfg_applied_reg <= 1'b0;
        end else begin
            ready_reg       <= i_Enable;
            cfg_applied_reg <= apply_now;

            if (rd_stb) begin
                rdata_reg <= rdata_next;
            end

            if (apply_now) begin
                active_ctrl_reg <= shadow_ctrl_reg;
                active_div_reg  <= shadow_div_reg;
            end

            if (wr_ctrl) begin
                shadow_ctrl_reg <= i_Data[7:0];
            end
            if (wr_div) begin
                shadow_div_reg <= div_wr_val;
            end
            pending_reg <= (pending_reg & ~apply_now) | wr_ctrl | wr_div;

            // Event beats clear when both arrive together.
            overrun_reg <= (overrun_reg & ~w1c[0]) | i_Rx_Overrun;
            parity_reg  <= (parity_reg  & ~w1c[1]) | i_Parity_Err;
            frame_reg   <= (frame_reg   & ~w1c[2]) | i_Frame_Err;
        end
    end

`ifdef STATUS_IRQ_EN
    logic [4:0] irq_en_reg;
    logic       tx_done_reg;
    logic       tx_busy_d_reg;
    logic       irq_reg;
    logic [4:0] irq_causes;

    assign irq_causes  = {tx_done_reg, frame_reg, parity_reg, overrun_reg, i_Rx_Full};
    assign irq_en_val  = irq_en_reg;
    assign tx_done_val = tx_done_reg;
    assign o_Irq       = irq_reg;

    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            irq_en_reg    <= 5'b0;
            tx_done_reg   <= 1'b0;
            tx_busy_d_reg <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            tx_busy_d_reg <= i_Tx_Busy;
            // Falling edge of TX busy marks the end of a transmission.
            tx_done_reg   <= (tx_done_reg & ~w1c[3]) | (tx_busy_d_reg & ~i_Tx_Busy);
            if (wr_irq_en) begin
                irq_en_reg <= i_Data[4:0];
            end
            irq_reg <= |(irq_en_reg & irq_causes);
        end
    end
`else
    assign irq_en_val  = 5'b0;
    assign tx_done_val = 1'b0;
    assign o_Irq       = 1'b0;
`endif

    // Bits that only matter in some builds or widths.
    logic unused_inputs;
    assign unused_inputs = ^{i_Data, w1c, wr_irq_en};

    assign o_Rdata       = rdata_reg;
    assign o_Ready       = ready_reg;
    assign o_Cfg_Applied = cfg_applied_reg;
    assign o_Baud        = active_ctrl_reg[5] ? active_div_reg : baud_tab[active_ctrl_reg[2:0]];
    assign o_Parity      = active_ctrl_reg[4:3];
    assign o_Tx_En       = active_ctrl_reg[6];
    assign o_Rx_En       = active_ctrl_reg[7];

endmodule
